tdm_demux_1x4: RTL

- Time-division 1-to-4 demultiplexer and deserializer. It is the distribution counterpart of the team's 4x1 selector blocks.
- Accepts a serial word stream on a valid/ready handshake and routes successive words to lanes 0..3 with an internal slot counter.
- Presents each completed 4-lane frame as a registered parallel word with its own valid/ready handshake.
- Sits between a serial source (shift or bus front end) and parallel consumers.

---
 rtl/tdm_demux_1x4_pkg.sv | 12 +
 rtl/tdm_demux_1x4_if.sv | 28 ++
 rtl/tdm_slot_ctr.sv | 28 ++
 rtl/tdm_demux_1x4.sv | 108 ++++++++++
 4 files changed

// File: rtl/tdm_demux_1x4_pkg.sv
// Shared types and constants for the 1-to-4 TDM demultiplexer.
package tdm_demux_1x4_pkg;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

   localparam int NUM_LANES = 4;
   localparam int SLOT_W    = 2;

endpackage

// File: rtl/tdm_demux_1x4_if.sv
// Serial input and parallel frame output bundle of the TDM demultiplexer.
// Both sides use valid/ready: a transfer happens on a rising edge where valid
// and ready are both high; valid never waits on ready, and held data is stable.
interface tdm_demux_1x4_if #(parameter int W = 8);

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         in_sync;
   logic         frame_valid;
   logic         frame_ready;
   logic [W-1:0] lane0;
   logic [W-1:0] lane1;
   logic [W-1:0] lane2;
   logic [W-1:0] lane3;
   logic         sync_err;

   modport slave (
      input  in_valid, in_data, in_sync, frame_ready,
      output in_ready, frame_valid, lane0, lane1, lane2, lane3, sync_err
   );

   modport master (
      output in_valid, in_data, in_sync, frame_ready,
      input  in_ready, frame_valid, lane0, lane1, lane2, lane3, sync_err
   );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Lane slot counter: wraps mod 4, can be cleared or realigned to slot 1.
module tdm_slot_ctr
   import tdm_demux_1x4_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              load1,
   input  logic              clr,
   output logic [SLOT_W-1:0] slot,
   output logic              term
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot <= '0;
      end else if (clr) begin
         slot <= '0;
      end else if (load1) begin
         slot <= SLOT_W'(1);
      end else if (inc) begin
         slot <= slot + 1'b1;
      end
   end

   assign term = (slot == SLOT_W'(NUM_LANES - 1));

endmodule

// File: rtl/tdm_demux_1x4.sv
// Time-division 1-to-4 demultiplexer: collects four serial words into a
// fill buffer and publishes them as one registered parallel frame.
module tdm_demux_1x4
   import tdm_demux_1x4_pkg::*;
#(
   parameter int W       = 8,
   parameter bit SYNC_EN = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   tdm_demux_1x4_if.slave bus,
   output state_e         state_dbg
);

   state_e            state, state_nxt;
   logic              accept, sync_hit;
   logic              ctr_inc, ctr_load1, ctr_clr;
   logic              lane_we, buf_we, err_nxt;
   logic [SLOT_W-1:0] buf_idx;
   logic [SLOT_W-1:0] slot;
   logic              term;
   logic [W-1:0]      fill_buf [NUM_LANES];

   tdm_slot_ctr u_slot_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (ctr_inc),
      .load1 (ctr_load1),
      .clr   (ctr_clr),
      .slot  (slot),
      .term  (term)
   );

   // In HOLD the input only moves when the held frame leaves on the same edge.
   assign bus.in_ready    = (state == FILL) ? 1'b1 : bus.frame_ready;
   assign bus.frame_valid = (state == HOLD);
   assign accept          = bus.in_valid && bus.in_ready;
   assign state_dbg       = state;

   always_comb begin
      state_nxt = state;
      ctr_inc   = 1'b0;
      ctr_load1 = 1'b0;
      ctr_clr   = 1'b0;
      lane_we   = 1'b0;
      buf_we    = 1'b0;
      err_nxt   = 1'b0;
      sync_hit  = SYNC_EN && accept && bus.in_sync;
      buf_idx   = sync_hit ? '0 : slot;
      unique case (state)
         FILL: begin
            if (accept) begin
               buf_we = 1'b1;
               if (sync_hit) begin
                  ctr_load1 = 1'b1;
                  err_nxt   = (slot != '0);
               end else if (term) begin
                  lane_we   = 1'b1;
                  ctr_clr   = 1'b1;
                  state_nxt = HOLD;
               end else begin
                  ctr_inc = 1'b1;
               end
            end
         end
         HOLD: begin
            // slot is 0 here, so an accepted word (sync or not) lands in slot 0.
            if (bus.frame_ready) begin
               state_nxt = FILL;
               if (accept) begin
                  buf_we  = 1'b1;
                  ctr_inc = 1'b1;
               end
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= FILL;
         bus.sync_err <= 1'b0;
      end else begin
         state        <= state_nxt;
         bus.sync_err <= err_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_LANES; i++) fill_buf[i] <= '0;
         bus.lane0 <= '0;
         bus.lane1 <= '0;
         bus.lane2 <= '0;
         bus.lane3 <= '0;
      end else begin
         if (buf_we) fill_buf[buf_idx] <= bus.in_data;
         if (lane_we) begin
            bus.lane0 <= fill_buf[0];
            bus.lane1 <= fill_buf[1];
            bus.lane2 <= fill_buf[2];
            bus.lane3 <= bus.in_data;
         end
      end
   end

endmodule
